// File: rtl/rp_bus_pkg.sv
// rp_bus_pkg: shared types and helpers for the rp_core data bus.
// Used by bus responders and core-side bus adapters.
package rp_bus_pkg;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_ACK  = 2'd2
  } rsp_state_e;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int BUS_SW = BUS_DW / 8;

  typedef struct packed {
    logic              wen;
    logic [BUS_AW-1:0] adr;
    logic [BUS_SW-1:0] sel;
    logic [BUS_DW-1:0] wdt;
  } bus_xfer_t;

  function automatic int lg2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/rp_mem_ram.sv
// rp_mem_ram: single-port synchronous RAM with byte-lane writes.
// Registered read; both ports act only when en is high.
module rp_mem_ram
  import rp_bus_pkg::*;
#(
  parameter int DW    = 32,
  parameter int SW    = DW / 8,
  parameter int DEPTH = 1024,
  parameter int IW    = lg2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          wen,
  input  logic [SW-1:0] sel,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] wdt,
  output logic [DW-1:0] rdt
);

  logic [DW-1:0] mem [DEPTH];

  // Lane-masked write and read-old-data, gated by en.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < SW; i++)
        if (wen && sel[i])
          mem[idx][i*8 +: 8] <= wdt[i*8 +: 8];
      rdt <= mem[idx];
    end
  end

endmodule

// File: rtl/rp_mem_rsp.sv
// rp_mem_rsp: data-bus responder with configurable wait states.
// Owns the req/ack handshake; storage lives in rp_mem_ram.
module rp_mem_rsp
  import rp_bus_pkg::*;
#(
  parameter int            AW   = 32,
  parameter int            DW   = 32,
  parameter int            SW   = DW / 8,
  parameter int            SIZE = 4096,
  parameter logic [AW-1:0] BASE = '0,
  parameter int            LAT  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          wen,
  input  logic [AW-1:0] adr,
  input  logic [SW-1:0] sel,
  input  logic [DW-1:0] wdt,
  output logic [DW-1:0] rdt,
  output logic          ack,
  output logic          err
);

  localparam int LS    = lg2(SIZE);
  localparam int LW    = lg2(SW);
  localparam int IW    = LS - LW;
  localparam int DEPTH = SIZE / SW;

  localparam logic [1:0] IDLE = RSP_IDLE;
  localparam logic [1:0] WAIT = RSP_WAIT;
  localparam logic [1:0] ACK  = RSP_ACK;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          cap_wen;
  logic [AW-1:0] cap_adr;
  logic [SW-1:0] cap_sel;
  logic [DW-1:0] cap_wdt;
  logic          a_wen;
  logic [AW-1:0] a_adr;
  logic [SW-1:0] a_sel;
  logic [DW-1:0] a_wdt;
  logic [AW-1:0] off;
  logic          oor;
  logic          go_ack;
  logic          ram_en;
  logic          zero;
  logic [DW-1:0] ram_rdt;

  // Access uses live inputs on the accept edge, else the capture.
  always_comb begin
    a_wen = cap_wen;
    a_adr = cap_adr;
    a_sel = cap_sel;
    a_wdt = cap_wdt;
    if (state == IDLE) begin
      a_wen = wen;
      a_adr = adr;
      a_sel = sel;
      a_wdt = wdt;
    end
  end

  assign off = a_adr - BASE;
  assign oor = (a_adr < BASE) ||
               ({1'b0, off} >= (AW+1)'(SIZE));

  // Edge that enters ACK: accept with LAT=1, or last wait state.
  always_comb begin
    go_ack = 1'b0;
    unique case (1'b1)
      state == IDLE: go_ack = req && (LAT == 1);
      state == WAIT: go_ack = req && (cnt == 4'd1);
      default:       go_ack = 1'b0;
    endcase
  end

  // A write in progress is dropped if rst is high at that edge.
  assign ram_en = go_ack && !oor && !rst;
  assign rdt    = zero ? '0 : ram_rdt;

  // Handshake FSM: accept, count wait states, pulse ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      zero    <= 1'b1;
      cap_wen <= 1'b0;
      cap_adr <= '0;
      cap_sel <= '0;
      cap_wdt <= '0;
    end else begin
      ack <= go_ack;
      err <= go_ack && oor;
      if (go_ack) zero <= oor;
      unique case (1'b1)
        state == IDLE: begin
          if (req) begin
            cap_wen <= wen;
            cap_adr <= adr;
            cap_sel <= sel;
            cap_wdt <= wdt;
            if (LAT == 1) begin
              state <= ACK;
            end else begin
              cnt   <= 4'(LAT - 1);
              state <= WAIT;
            end
          end
        end
        state == WAIT: begin
          if (!req) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state <= ACK;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rp_mem_ram #(
    .DW    (DW),
    .SW    (SW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk (clk),
    .en  (ram_en),
    .wen (a_wen),
    .sel (a_sel),
    .idx (off[LS-1:LW]),
    .wdt (a_wdt),
    .rdt (ram_rdt)
  );

endmodule

// File: tb/tb_rp_mem_rsp.sv
// tb_rp_mem_rsp: scoreboard bench for rp_mem_rsp.
// Four responders with LAT 1, 4, 2 and 7 share clk and rst.
module tb_rp_mem_rsp;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] rdt;
    int          due;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_s [4];
  logic        wen_s [4];
  logic [31:0] adr_s [4];
  logic [3:0]  sel_s [4];
  logic [31:0] wdt_s [4];
  logic [31:0] rdt_s [4];
  logic        ack_s [4];
  logic        err_s [4];

  exp_t        sbq [4][$];
  int          issued [4];
  int          ackcnt [4];
  logic [31:0] mdl [4][16];
  int          nchk = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          xid = 0;
  exp_t        me;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 4 :
                       (g == 2) ? 2 : 7;
    rp_mem_rsp #(
      .LAT (L)
    ) dut (
      .clk (clk),
      .rst (rst),
      .req (req_s[g]),
      .wen (wen_s[g]),
      .adr (adr_s[g]),
      .sel (sel_s[g]),
      .wdt (wdt_s[g]),
      .rdt (rdt_s[g]),
      .ack (ack_s[g]),
      .err (err_s[g])
    );
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 2 : 7;
  endfunction

  task automatic cmp(input string nm, input int g, input int id,
                     input logic [31:0] act, input logic [31:0] exp_v);
    nchk++;
    if (act !== exp_v) begin
      nfail++;
      $display("FAIL %s dut%0d xfer%0d got %h expected %h",
               nm, g, id, act, exp_v);
    end
  endtask

  // Monitor: pop the expectation for every ack and compare.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (ack_s[g] === 1'b1) begin
        ackcnt[g]++;
        if (sbq[g].size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_ack dut%0d cycle %0d", g, cyc);
        end else begin
          me = sbq[g].pop_front();
          cmp("ack_cycle", g, me.id, cyc, me.due);
          cmp("err", g, me.id, 32'(err_s[g]), 32'(me.err));
          if (me.chk) cmp("rdt", g, me.id, rdt_s[g], me.rdt);
        end
      end
    end
  end

  task automatic xfer(input int g, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      input logic e_err, input logic c,
                      input logic [31:0] e_rdt);
    exp_t e;
    bit   got;
    e.err = e_err;
    e.chk = c;
    e.rdt = e_rdt;
    e.due = cyc + lat_of(g);
    e.id  = xid;
    xid++;
    sbq[g].push_back(e);
    issued[g]++;
    req_s[g] = 1'b1;
    wen_s[g] = w;
    adr_s[g] = a;
    sel_s[g] = s;
    wdt_s[g] = d;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (ack_s[g] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      nchk++;
      nfail++;
      $display("FAIL ack_timeout dut%0d xfer%0d got none expected ack", g, e.id);
      void'(sbq[g].pop_back());
    end
    @(posedge clk);
    #1;
    req_s[g] = 1'b0;
  endtask

  task automatic wr(input int g, input logic [31:0] a,
                    input logic [3:0] s, input logic [31:0] d,
                    input logic e_err);
    xfer(g, 1'b1, a, s, d, e_err, e_err, 32'h0);
  endtask

  task automatic rd(input int g, input logic [31:0] a,
                    input logic e_err, input logic [31:0] e_rdt);
    xfer(g, 1'b0, a, 4'h0, 32'h0, e_err, 1'b1, e_rdt);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [31:0] d;
    logic [3:0] s;
    int j;
    for (int i = 0; i < 4; i++) begin
      req_s[i] = 1'b0;
      wen_s[i] = 1'b0;
      adr_s[i] = '0;
      sel_s[i] = '0;
      wdt_s[i] = '0;
      issued[i] = 0;
      ackcnt[i] = 0;
    end
    #2 rst = 1'b1;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      cmp("rst_ack", i, -1, 32'(ack_s[i]), 32'h0);
      cmp("rst_err", i, -1, 32'(err_s[i]), 32'h0);
      cmp("rst_rdt", i, -1, rdt_s[i], 32'h0);
    end
    rst = 1'b0;
    tick(2);

    wr(0, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    rd(0, 32'h10, 1'b0, 32'hDEADBEEF);
    wr(0, 32'h10, 4'b0010, 32'h0000_5500, 1'b0);
    rd(0, 32'h10, 1'b0, 32'hDEAD55EF);
    wr(0, 32'h10, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    rd(0, 32'h12, 1'b0, 32'hDEAD55EF);

    wr(0, 32'h0FFC, 4'hF, 32'h1234_5678, 1'b0);
    wr(0, 32'h1000, 4'hF, 32'hAAAA_AAAA, 1'b1);
    wr(0, 32'h1FFC, 4'hF, 32'h5555_5555, 1'b1);
    wr(0, 32'hFFFF_FFFC, 4'hF, 32'h6666_6666, 1'b1);
    rd(0, 32'h1000, 1'b1, 32'h0);
    rd(0, 32'h0FFC, 1'b0, 32'h1234_5678);

    wr(1, 32'h0, 4'hF, 32'h1111_1111, 1'b0);
    wr(1, 32'h4, 4'hF, 32'h2222_2222, 1'b0);
    tick(3);
    rd(1, 32'h0, 1'b0, 32'h1111_1111);
    rd(1, 32'h4, 1'b0, 32'h2222_2222);

    wr(1, 32'h30, 4'hF, 32'h3333_3333, 1'b0);
    req_s[1] = 1'b1;
    wen_s[1] = 1'b1;
    adr_s[1] = 32'h30;
    sel_s[1] = 4'hF;
    wdt_s[1] = 32'hDDDD_DDDD;
    tick(2);
    req_s[1] = 1'b0;
    tick(8);
    rd(1, 32'h30, 1'b0, 32'h3333_3333);

    wr(1, 32'h20, 4'hF, 32'h4444_4444, 1'b0);
    req_s[1] = 1'b1;
    wen_s[1] = 1'b1;
    adr_s[1] = 32'h20;
    sel_s[1] = 4'hF;
    wdt_s[1] = 32'hEEEE_EEEE;
    tick(2);
    rst = 1'b1;
    req_s[1] = 1'b0;
    tick(1);
    rst = 1'b0;
    rd(1, 32'h20, 1'b0, 32'h4444_4444);

    wr(0, 32'h40, 4'hF, 32'h0101_0101, 1'b0);
    req_s[0] = 1'b1;
    wen_s[0] = 1'b1;
    adr_s[0] = 32'h40;
    sel_s[0] = 4'hF;
    wdt_s[0] = 32'h0202_0202;
    tick(1);
    cmp("ack_before_rst", 0, -1, 32'(ack_s[0]), 32'h1);
    rst = 1'b1;
    #1;
    cmp("ack_async_clr", 0, -1, 32'(ack_s[0]), 32'h0);
    req_s[0] = 1'b0;
    tick(1);
    rst = 1'b0;
    rd(0, 32'h40, 1'b0, 32'h0202_0202);

    for (int gi = 0; gi < 3; gi++) begin
      g = (gi == 0) ? 0 : (gi == 1) ? 2 : 3;
      for (int k = 0; k < 16; k++) begin
        d = $urandom;
        mdl[g][k] = d;
        wr(g, 32'h200 + 32'(k * 4), 4'hF, d, 1'b0);
      end
      for (int n = 0; n < 30; n++) begin
        j = $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 1) begin
          d = $urandom;
          s = 4'($urandom_range(0, 15));
          for (int b = 0; b < 4; b++)
            if (s[b]) mdl[g][j][b*8 +: 8] = d[b*8 +: 8];
          wr(g, 32'h200 + 32'(j * 4), s, d, 1'b0);
        end else begin
          rd(g, 32'h200 + 32'(j * 4), 1'b0, mdl[g][j]);
        end
      end
    end

    tick(12);
    for (int i = 0; i < 4; i++) begin
      cmp("ack_count", i, -1, 32'(ackcnt[i]), 32'(issued[i]));
      cmp("sb_empty", i, -1, 32'(sbq[i].size()), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/rp_mem_rsp.md
Name: rp_mem_rsp

Overview:
- Data-bus responder (memory slave) for the rp_core load/store interface. It terminates req/wen/adr/sel/wdt/rdt/ack transfers into an internal byte-lane-writable RAM.
- Wait-state latency is configurable.
- Used as tightly-coupled data memory and as the bus model in core benches.

Parameters:
- AW, 32, address width (matches core DAW)
- DW, 32, data width (matches core DDW)
- SW, DW/8, byte-select width
- SIZE, 4096, memory size in bytes; power of two, multiple of SW
- BASE, '0, base byte address; must be SIZE-aligned
- LAT, 1, wait latency in cycles from request accept to ack; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  1  transfer request (read or write)
- wen  in  1  write enable; 1=write, 0=read
- adr  in  AW  byte address; low log2(SW) bits ignored (word access)
- sel  in  SW  byte select, one bit per lane
- wdt  in  SW x 8  write data
- rdt  out  SW x 8  read data, valid only while ack=1
- ack  out  1  transfer acknowledge, single-cycle pulse
- err  out  1  out-of-range flag, valid only while ack=1

Behaviour:
- Clock and reset: reset rst, asynchronous, active-high; clock clk. All flops reset by rst.
- Reset values: ack=0, err=0, rdt='0, FSM=IDLE, counter=0. RAM contents are not reset.
- Handshake:
  - Initiator holds req/wen/adr/sel/wdt stable from req rise until it samples ack=1.
  - A transfer completes on the cycle where req=1 and ack=1.
  - ack is registered and is a 1-cycle pulse.
- FSM states:
  - IDLE: on req=1, capture wen/adr/sel/wdt. If LAT=1, go to ACK; otherwise load cnt=LAT-1 and go to WAIT.
  - WAIT: decrement cnt. When cnt==1, go to ACK. If req=0 (protocol violation or abort), go to IDLE with no RAM access.
  - ACK: ack=1 for this cycle only. Next state is IDLE; the ACK cycle never accepts a request, because req is still the old transfer's.
- Latency: req first high at cycle N -> ack=1 at cycle N+LAT. Back-to-back throughput is one transfer per LAT+1 cycles.
- RAM access timing:
  - The access happens on the clock edge that enters ACK.
  - Writes update only lanes with sel[i]=1.
  - Reads return the full word into rdt regardless of sel; the initiator extracts lanes.
  - Lanes with sel=0 on a write are not modified.
- Address decode:
  - Word index = (adr-BASE)[log2(SIZE)-1:log2(SW)].
  - Out of range (adr<BASE or adr>=BASE+SIZE): ack still pulses, err=1, rdt='0, and no write occurs. err=0 otherwise.
- Boundary conditions:
  - Highest word (BASE+SIZE-SW) is accessible.
  - Index arithmetic uses no wrap-around; the range check is done in full AW width.
  - sel='0 write: acked, no lanes modified.
  - Reset mid-WAIT: FSM returns to IDLE, no write performed, ack stays 0.
  - Reset asserted on the cycle ack is high: ack clears asynchronously.
  - The RAM write on the same edge completes only if rst was low at that edge.
- rdt holds its last value when ack=0; it changes only on the ACK entry edge.

Decomposition:
- Shared package rp_bus_pkg:
  - responder FSM enum (IDLE, WAIT, ACK)
  - helper function for log2 of SIZE/SW
  - bus transfer struct {wen, adr, sel, wdt}, reusable by core-side bus adapters.
- Sub-module rp_mem_ram:
  - single-port synchronous RAM, parameters DW/SW/depth
  - per-lane write enables, registered read
  - inferred as block RAM; rp_mem_rsp instantiates it and owns all handshake logic.

Test Plan:
- Reset release, LAT=1: write adr=0x0000_0010, sel=4'b1111, wdt=0xDEADBEEF, req held -> ack=1 exactly 1 cycle after req. Then read adr=0x10 -> ack after 1 cycle, rdt=0xDEADBEEF, err=0.
- Byte-lane write over 0xDEADBEEF at 0x10: write sel=4'b0010, wdt=0x0000_5500 -> subsequent read of 0x10 returns 0xDEAD55EF. sel=4'b0000 write -> word unchanged, ack still pulses.
- LAT=4: read request at cycle 10 -> ack only at cycle 14, ack low in cycles 11-13. Back-to-back reads of 0x0/0x4 -> second ack at cycle 19.
- Out of range, SIZE=4096, BASE=0: write adr=0x1000 -> ack=1, err=1, rdt=0. Read 0x0FFC unchanged; highest word 0x0FFC readable with err=0.
- Abort and reset, LAT=4: drop req in WAIT -> no ack, memory unchanged. Assert rst mid-WAIT of a write to 0x20 -> ack stays 0, 0x20 unchanged after reset, FSM accepts a new request 1 cycle after rst deasserts.
- Randomized read/write stream against a scoreboard model, LAT in {1,2,7}, random sel -> every rdt matches the model; exactly one ack per accepted req.
